// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle between game logic and the compositor: pixel position, sprite table,
// overlay/background colours in; RGB and latched mode out.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COLOR_W     = 4,
    parameter int SIZE_W      = 7
);
    logic [9:0]                       pixel_x;
    logic [9:0]                       pixel_y;
    logic                             video_on;
    logic                             frame_start;
    logic [1:0]                       mode;
    logic [10*NUM_SPRITES-1:0]        spr_x;
    logic [10*NUM_SPRITES-1:0]        spr_y;
    logic [SIZE_W*NUM_SPRITES-1:0]    spr_w;
    logic [SIZE_W*NUM_SPRITES-1:0]    spr_h;
    logic [NUM_SPRITES-1:0]           spr_en;
    logic [NUM_SPRITES-1:0]           spr_blink;
    logic [3*COLOR_W*NUM_SPRITES-1:0] spr_color;
    logic                             overlay_on;
    logic [3*COLOR_W-1:0]             overlay_color;
    logic [3*COLOR_W-1:0]             bg_color;
    logic [COLOR_W-1:0]               red;
    logic [COLOR_W-1:0]               green;
    logic [COLOR_W-1:0]               blue;
    logic [1:0]                       mode_active;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start, mode,
        output spr_x, spr_y, spr_w, spr_h, spr_en, spr_blink, spr_color,
        output overlay_on, overlay_color, bg_color,
        input  red, green, blue, mode_active
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start, mode,
        input  spr_x, spr_y, spr_w, spr_h, spr_en, spr_blink, spr_color,
        input  overlay_on, overlay_color, bg_color,
        output red, green, blue, mode_active
    );
endinterface

// File: rtl/sprite_compositor.sv
// Priority sprite/overlay/background compositor with frame-latched screen mode and blink.
// Two-stage pipeline (inputs at cycle n drive RGB at n+2); free-running, no backpressure.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int COLOR_W     = 4,
    parameter int SIZE_W      = 7,
    parameter int BLINK_LOG2  = 5
) (
    input logic                clk_0,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int RGB_W = 3 * COLOR_W;

    logic [BLINK_LOG2-1:0]        frame_cnt_q, frame_cnt_d;
    logic [1:0]                   mode_active_q, mode_active_d;
    logic [NUM_SPRITES-1:0]       hit_q, hit_d;
    logic                         ovl_on_q;
    logic                         vid_q;
    logic [2:0]                   bar_q;
    logic [RGB_W*NUM_SPRITES-1:0] spr_color_q;
    logic [RGB_W-1:0]             ovl_color_q;
    logic [RGB_W-1:0]             bg_color_q;
    logic [RGB_W-1:0]             rgb_q, rgb_d;
    logic [RGB_W-1:0]             play_color;
    logic                         blink_off;

    assign blink_off = frame_cnt_q[BLINK_LOG2-1];

    // Bounds are widened to 11 bits so a sprite hanging off column/line 1023 clips instead of wrapping.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
        logic [10:0] x_lo, x_hi, y_lo, y_hi, px, py;
        assign x_lo = {1'b0, bus.spr_x[10*gi +: 10]};
        assign y_lo = {1'b0, bus.spr_y[10*gi +: 10]};
        assign x_hi = x_lo + {{(11-SIZE_W){1'b0}}, bus.spr_w[SIZE_W*gi +: SIZE_W]};
        assign y_hi = y_lo + {{(11-SIZE_W){1'b0}}, bus.spr_h[SIZE_W*gi +: SIZE_W]};
        assign px   = {1'b0, bus.pixel_x};
        assign py   = {1'b0, bus.pixel_y};
        assign hit_d[gi] = bus.spr_en[gi] && !(bus.spr_blink[gi] && blink_off)
                           && (px >= x_lo) && (px < x_hi)
                           && (py >= y_lo) && (py < y_hi);
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        mode_active_d = mode_active_q;
        if (bus.frame_start) begin
            frame_cnt_d   = frame_cnt_q + 1'b1;
            mode_active_d = bus.mode;
        end
    end

    always_comb begin
        play_color = ovl_on_q ? ovl_color_q : bg_color_q;
        // Walk from the highest index down so the lowest-index hit is the last to overwrite.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i]) play_color = spr_color_q[RGB_W*i +: RGB_W];
        end

        case (mode_active_q)
            2'd0:    rgb_d = play_color;
            2'd1,
            2'd2:    rgb_d = ovl_on_q ? ovl_color_q : '0;
            default: rgb_d = {{COLOR_W{bar_q[2]}}, {COLOR_W{bar_q[1]}}, {COLOR_W{bar_q[0]}}};
        endcase

        if (!vid_q) rgb_d = '0;
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            mode_active_q <= 2'd0;
            hit_q         <= '0;
            ovl_on_q      <= 1'b0;
            vid_q         <= 1'b0;
            bar_q         <= 3'd0;
            spr_color_q   <= '0;
            ovl_color_q   <= '0;
            bg_color_q    <= '0;
            rgb_q         <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            mode_active_q <= mode_active_d;
            hit_q         <= hit_d;
            ovl_on_q      <= bus.overlay_on;
            vid_q         <= bus.video_on;
            bar_q         <= bus.pixel_x[9:7];
            spr_color_q   <= bus.spr_color;
            ovl_color_q   <= bus.overlay_color;
            bg_color_q    <= bus.bg_color;
            rgb_q         <= rgb_d;
        end
    end

    assign bus.red         = rgb_q[RGB_W-1 -: COLOR_W];
    assign bus.green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue        = rgb_q[COLOR_W-1:0];
    assign bus.mode_active = mode_active_q;
endmodule
